// File: rtl/fifo_18_tx_serializer.sv
// Reads 48-bit words from the fifo_18 read port and sends them to a byte transmitter, most significant byte first.
// An optional sync byte goes before each word. This block absorbs the FIFO's one-cycle registered read latency.
module fifo_18_tx_serializer #(
    parameter int                    WORD_WIDTH = 48,
    parameter int                    BYTE_WIDTH = 8,
    parameter bit                    SYNC_EN    = 1'b1,
    parameter logic [BYTE_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP       = 3'd1,
        S_LATCH     = 3'd2,
        S_SEND_SYNC = 3'd3,
        S_SEND      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BYTE_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    rd_en_q, rd_en_d;
    logic                    busy_q, busy_d;
    logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic                    hs_s;
    logic                    can_pop_s;

    assign hs_s      = tx_valid_q && tx_ready;
    assign can_pop_s = enable && !fifo_empty;

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (can_pop_s) begin
                    state_d = S_POP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_POP: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                tx_valid_d = 1'b1;
                idx_d      = {IDX_W{1'b0}};
                if (SYNC_EN) begin
                    shift_d   = fifo_data;
                    tx_data_d = SYNC_BYTE;
                    state_d   = S_SEND_SYNC;
                end else begin
                    tx_data_d = fifo_data[WORD_WIDTH-1 -: BYTE_WIDTH];
                    shift_d   = {fifo_data[WORD_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
                    state_d   = S_SEND;
                end
            end
            S_SEND_SYNC: begin
                if (hs_s) begin
                    tx_data_d = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                    shift_d   = {shift_q[WORD_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
                    idx_d     = {IDX_W{1'b0}};
                    state_d   = S_SEND;
                end else begin
                    state_d = S_SEND_SYNC;
                end
            end
            S_SEND: begin
                if (hs_s && (idx_q != LAST_IDX)) begin
                    tx_data_d = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                    shift_d   = {shift_q[WORD_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
                    idx_d     = idx_q + IDX_W'(1);
                end else if (hs_s) begin
                    // Last byte accepted. Go straight back to POP if more work is waiting.
                    word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    tx_valid_d = 1'b0;
                    if (can_pop_s) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        rd_en_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= {WORD_WIDTH{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            tx_data_q  <= {BYTE_WIDTH{1'b0}};
            tx_valid_q <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            word_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_18_tx_serializer.sv
// Directed bench for fifo_18_tx_serializer. Instance a uses a sync byte and a 4-bit counter; instance b has no sync byte.
// A FIFO model feeds each instance, and a byte scoreboard checks every handshake.
module tb_fifo_18_tx_serializer;

    logic        clk = 1'b0;
    logic        rst, enable, tx_ready;
    logic        fempty_a, fempty_b;
    logic [47:0] fdata_a, fdata_b;
    logic        rd_a, txv_a, busy_a, rd_b, txv_b, busy_b;
    logic [7:0]  txd_a, txd_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;

    logic [47:0] fqa[$];
    logic [47:0] fqb[$];
    logic [7:0]  expa[$];
    logic [7:0]  expb[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs[2];
    int rdc[2];
    int last_hs[2];
    int rd_gap[2];
    bit hold[2];
    logic [7:0] hold_d[2];

    fifo_18_tx_serializer #(.SYNC_EN(1'b1), .CNT_WIDTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fempty_a), .fifo_data(fdata_a),
        .fifo_rd_en(rd_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready),
        .busy(busy_a), .word_cnt(cnt_a)
    );

    fifo_18_tx_serializer #(.SYNC_EN(1'b0), .CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fempty_b), .fifo_data(fdata_b),
        .fifo_rd_en(rd_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready),
        .busy(busy_b), .word_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-instance monitor, called just before each rising edge with that edge's inputs in place.
    task automatic mon_one(input int p, input logic v, input logic [7:0] d, input logic rd, input logic fe);
        logic [7:0] e;
        int         n;
        if (hold[p]) begin
            chk($sformatf("hold_valid%0d", p), 64'(v), 64'd1);
            chk($sformatf("hold_data%0d", p), 64'(d), 64'(hold_d[p]));
        end
        if (v && tx_ready) begin
            hs[p]++;
            last_hs[p] = cyc;
            n = (p == 0) ? expa.size() : expb.size();
            chk($sformatf("sb_has_byte%0d", p), 64'(n != 0), 64'd1);
            if (n != 0) begin
                e = (p == 0) ? expa.pop_front() : expb.pop_front();
                chk($sformatf("tx_byte%0d", p), 64'(d), 64'(e));
            end
        end
        if (rd) begin
            rdc[p]++;
            rd_gap[p] = cyc - last_hs[p];
            chk($sformatf("rd_while_empty%0d", p), 64'(fe), 64'd0);
        end
        hold[p]   = v && !tx_ready;
        hold_d[p] = d;
    endtask

    task automatic step();
        bit pa, pb;
        mon_one(0, txv_a, txd_a, rd_a, fempty_a);
        mon_one(1, txv_b, txd_b, rd_b, fempty_b);
        pa = rd_a && !fempty_a;
        pb = rd_b && !fempty_b;
        @(posedge clk);
        #1;
        if (pa) fdata_a = fqa.pop_front();
        if (pb) fdata_b = fqb.pop_front();
        fempty_a = (fqa.size() == 0);
        fempty_b = (fqb.size() == 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_a(input logic [47:0] w);
        fqa.push_back(w);
        fempty_a = 1'b0;
        expa.push_back(8'hA5);
        for (int k = 5; k >= 0; k--) expa.push_back(w[k*8 +: 8]);
    endtask

    task automatic push_b(input logic [47:0] w);
        fqb.push_back(w);
        fempty_b = 1'b0;
        for (int k = 5; k >= 0; k--) expb.push_back(w[k*8 +: 8]);
    endtask

    task automatic drain(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            step();
            if (!busy_a && !busy_b && fqa.size() == 0 && fqb.size() == 0) break;
        end
        tx_ready = 1'b1;
        chk("drain_idle_a", 64'(busy_a), 64'd0);
        chk("drain_idle_b", 64'(busy_b), 64'd0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_rd", 64'(rd_a), 64'd0);
        chk("rst_valid", 64'(txv_a), 64'd0);
        chk("rst_data", 64'(txd_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        expa.delete();
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int h0, r0;
        logic [3:0]  pat;
        logic [47:0] w;
        rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        fempty_a = 1'b1; fempty_b = 1'b1; fdata_a = 48'd0; fdata_b = 48'd0;
        #3;
        chk("reset_rd_a", 64'(rd_a), 64'd0);
        chk("reset_valid_a", 64'(txv_a), 64'd0);
        chk("reset_busy_a", 64'(busy_a), 64'd0);
        chk("reset_cnt_a", 64'(cnt_a), 64'd0);
        chk("reset_data_a", 64'(txd_a), 64'd0);
        chk("reset_valid_b", 64'(txv_b), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // One word, ready held high: exact latency and 7 back-to-back bytes.
        push_a(48'h010203040506);
        enable = 1'b1; tx_ready = 1'b1;
        step();
        chk("t1_pop", 64'(rd_a), 64'd1);
        chk("t1_busy", 64'(busy_a), 64'd1);
        step();
        chk("t1_latch_rd", 64'(rd_a), 64'd0);
        chk("t1_latch_valid", 64'(txv_a), 64'd0);
        step();
        chk("t1_first_valid", 64'(txv_a), 64'd1);
        chk("t1_sync", 64'(txd_a), 64'hA5);
        repeat (7) step();
        chk("t1_busy_end", 64'(busy_a), 64'd0);
        chk("t1_valid_end", 64'(txv_a), 64'd0);
        chk("t1_cnt", 64'(cnt_a), 64'd1);
        chk("t1_hs", 64'(hs[0]), 64'd7);
        chk("t1_rd", 64'(rdc[0]), 64'd1);

        // tx_ready follows the 1-0-0-1 pattern.
        h0 = hs[0]; r0 = rdc[0]; pat = 4'b1001;
        push_a(48'h010203040506);
        for (int i = 0; i < 80; i++) begin
            tx_ready = pat[3 - (i % 4)];
            step();
            if (hs[0] == h0 + 7 && !busy_a) break;
        end
        tx_ready = 1'b1;
        chk("t2_hs", 64'(hs[0] - h0), 64'd7);
        chk("t2_rd", 64'(rdc[0] - r0), 64'd1);
        chk("t2_cnt", 64'(cnt_a), 64'd2);
        chk("t2_busy", 64'(busy_a), 64'd0);

        // Two preloaded words, sent back to back.
        h0 = hs[0]; r0 = rdc[0];
        enable = 1'b0;
        push_a(48'h111111111111);
        push_a(48'h222222222222);
        repeat (3) step();
        chk("t3_no_pop_disabled", 64'(rdc[0] - r0), 64'd0);
        enable = 1'b1;
        drain(60, 1'b0);
        chk("t3_rd_gap", 64'(rd_gap[0]), 64'd1);
        chk("t3_rd", 64'(rdc[0] - r0), 64'd2);
        chk("t3_hs", 64'(hs[0] - h0), 64'd14);
        chk("t3_cnt", 64'(cnt_a), 64'd4);
        chk("t3_empty", 64'(fempty_a), 64'd1);

        // Empty FIFO with enable high, then a gated pop.
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t4_rd", 64'(rd_a), 64'd0);
            chk("t4_valid", 64'(txv_a), 64'd0);
            chk("t4_busy", 64'(busy_a), 64'd0);
        end
        r0 = rdc[0];
        enable = 1'b0;
        push_a(48'hDEADBEEFCAFE);
        repeat (5) step();
        chk("t4_no_pop", 64'(rdc[0] - r0), 64'd0);
        chk("t4_idle", 64'(busy_a), 64'd0);
        enable = 1'b1;
        step();
        chk("t4_pop_now", 64'(rd_a), 64'd1);
        drain(40, 1'b0);
        chk("t4_cnt", 64'(cnt_a), 64'd5);

        // Asynchronous reset in the middle of a word.
        h0 = hs[0];
        push_a(48'h010203040506);
        for (int i = 0; i < 30 && hs[0] < h0 + 4; i++) step();
        chk("t5_reached_03", 64'(hs[0] - h0), 64'd4);
        async_reset();
        chk("t5_after_cnt", 64'(cnt_a), 64'd0);
        push_a(48'h010203040506);
        drain(30, 1'b0);
        chk("t5_cnt", 64'(cnt_a), 64'd1);
        chk("t5_sb_empty", 64'(expa.size()), 64'd0);

        // Counter wrap with a 4-bit counter; tx_ready is random.
        async_reset();
        h0 = hs[0];
        for (int i = 0; i < 15; i++) begin
            w = {$urandom(), 16'($urandom())};
            push_a(w);
        end
        drain(1200, 1'b1);
        chk("t6_cnt15", 64'(cnt_a), 64'd15);
        push_a(48'hFEDCBA987654);
        drain(100, 1'b1);
        chk("t6_wrap", 64'(cnt_a), 64'd0);
        chk("t6_hs", 64'(hs[0] - h0), 64'd112);
        chk("t6_sb_empty", 64'(expa.size()), 64'd0);

        // Instance without a sync byte: 6 bytes per word, data byte first.
        push_b(48'h0A0B0C0D0E0F);
        push_b(48'h123456789ABC);
        push_b(48'hA5A5A5A5A5A5);
        tx_ready = 1'b1;
        step();
        chk("b_pop", 64'(rd_b), 64'd1);
        step();
        step();
        chk("b_first_valid", 64'(txv_b), 64'd1);
        chk("b_first_byte", 64'(txd_b), 64'h0A);
        drain(200, 1'b1);
        chk("b_cnt", 64'(cnt_b), 64'd3);
        chk("b_hs", 64'(hs[1]), 64'd18);
        chk("b_rd", 64'(rdc[1]), 64'd3);
        chk("b_sb_empty", 64'(expb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
